// File: rtl/mac16_dot_seq.sv
// mac16_dot_seq: sequencer that turns one SB_MAC16 (16x16 signed multiply-
// accumulate) into a streaming dot-product engine.
//
// Ports:
//   CLK, RST          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand pair handshake; in_a, in_b signed 16-bit,
//                     in_last marks the final pair of a vector
//   out_valid/ready   result handshake; out_data is the 32-bit dot product
//                     at the head of a 2-entry first-word-fall-through FIFO
//   mac_ce, mac_a, mac_b, mac_oload  drive the DSP operand/control pins
//   mac_o             DSP accumulator output (running sum)
//
// Every issued cycle pushes a {valid, first, last} tag down a pipeline that
// mirrors the DSP latency. Tag stage i holds the pair that sits on mac_a/mac_b
// i cycles earlier. Stage 0 is the issue cycle itself.
module mac16_dot_seq #(
  parameter int MAC_LATENCY = 3,
  parameter int LOAD_DELAY  = 2,
  parameter int OUT_DEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        mac_ce,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic        mac_oload,
  input  logic [31:0] mac_o
);

  localparam logic [3:0] DEPTH_LIM = 4'(OUT_DEPTH);

  // registered state
  logic                 run_q,       run_d;
  logic                 mac_ce_q,    mac_ce_d;
  logic [15:0]          mac_a_q,     mac_a_d;
  logic [15:0]          mac_b_q,     mac_b_d;
  logic                 mac_oload_q, mac_oload_d;
  logic                 first_q,     first_d;
  logic [MAC_LATENCY:0] tag_v_q,     tag_v_d;
  logic [MAC_LATENCY:0] tag_f_q,     tag_f_d;
  logic [MAC_LATENCY:0] tag_l_q,     tag_l_d;
  logic [31:0]          mem_q [2];
  logic [31:0]          mem_d [2];
  logic                 wr_ptr_q,    wr_ptr_d;
  logic                 rd_ptr_q,    rd_ptr_d;
  logic [1:0]           count_q,     count_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_data_q,  out_data_d;

  // combinational helpers
  logic [3:0] inflight_s;
  logic [3:0] pending_s;
  logic       ready_s;
  logic       accept_s;
  logic       push_s;
  logic       pop_s;

  // Next-state logic: issue, tag shifting, oload timing and result FIFO.
  always_comb begin
    // Count vectors whose last pair is still travelling through the DSP;
    // together with FIFO occupancy this bounds the results we owe.
    inflight_s = 4'd0;
    for (int i = 0; i <= MAC_LATENCY; i++) begin
      inflight_s = inflight_s + 4'(tag_v_q[i] & tag_l_q[i]);
    end
    pending_s = inflight_s + {2'b00, count_q};

    // Only a closing pair can create a result, so only it is throttled.
    ready_s  = run_q & (~in_last | (pending_s < DEPTH_LIM));
    accept_s = in_valid & ready_s;

    run_d    = 1'b1;
    mac_ce_d = 1'b1;

    // Bubbles present zero operands so the accumulator is unchanged.
    mac_a_d = accept_s ? in_a : 16'd0;
    mac_b_d = accept_s ? in_b : 16'd0;

    first_d = accept_s ? in_last : first_q;

    tag_v_d = {tag_v_q[MAC_LATENCY-1:0], accept_s};
    tag_f_d = {tag_f_q[MAC_LATENCY-1:0], accept_s & first_q};
    tag_l_d = {tag_l_q[MAC_LATENCY-1:0], accept_s & in_last};

    // Registered one cycle early so oload lands LOAD_DELAY cycles after issue.
    mac_oload_d = tag_v_q[LOAD_DELAY-1] & tag_f_q[LOAD_DELAY-1];

    // Capture the running sum when a closing tag reaches the DSP output.
    push_s = tag_v_q[MAC_LATENCY] & tag_l_q[MAC_LATENCY];
    pop_s  = out_valid_q & out_ready;

    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    mem_d[wr_ptr_q] = push_s ? mac_o : mem_q[wr_ptr_q];

    wr_ptr_d = wr_ptr_q ^ push_s;
    rd_ptr_d = rd_ptr_q ^ pop_s;
    count_d  = count_q + {1'b0, push_s} - {1'b0, pop_s};

    // Head of the FIFO after this cycle's push/pop, registered for output.
    out_valid_d = (count_d != 2'd0);
    out_data_d  = mem_d[rd_ptr_d];
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q       <= 1'b0;
      mac_ce_q    <= 1'b0;
      mac_a_q     <= 16'd0;
      mac_b_q     <= 16'd0;
      mac_oload_q <= 1'b0;
      first_q     <= 1'b1;
      tag_v_q     <= '0;
      tag_f_q     <= '0;
      tag_l_q     <= '0;
      mem_q[0]    <= 32'd0;
      mem_q[1]    <= 32'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
    end else begin
      run_q       <= run_d;
      mac_ce_q    <= mac_ce_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_oload_q <= mac_oload_d;
      first_q     <= first_d;
      tag_v_q     <= tag_v_d;
      tag_f_q     <= tag_f_d;
      tag_l_q     <= tag_l_d;
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mac_ce    = mac_ce_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_oload = mac_oload_q;

endmodule

// File: tb/tb_mac16_dot_seq.sv
// Testbench for mac16_dot_seq: directed vectors with literal results plus a
// randomized stream, all checked against a behavioural dot-product model.
// A small SB_MAC16 model closes the loop on mac_a/mac_b/mac_oload -> mac_o.
module tb_mac16_dot_seq;

  localparam int L  = 3;
  localparam int LD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        mac_ce;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_oload;
  logic [31:0] mac_o = 32'd0;

  mac16_dot_seq #(.MAC_LATENCY(L), .LOAD_DELAY(LD), .OUT_DEPTH(2)) dut (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b), .mac_oload(mac_oload),
    .mac_o(mac_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // DSP model state, indexed by cycle
  logic [15:0] a_h [int];
  logic [15:0] b_h [int];
  logic [31:0] s_h [int];
  logic signed [31:0] dsp_acc = 32'sd0;
  logic signed [31:0] prod;

  // Reference model state
  typedef struct { int rdy; logic [31:0] val; } res_t;
  res_t        exp_q [$];
  logic        if_h [int];
  int          pending = 0;
  logic        first_m = 1'b1;
  logic        run_m = 1'b0;
  logic [15:0] exp_a = 16'd0;
  logic [15:0] exp_b = 16'd0;
  logic signed [31:0] sum_m = 32'sd0;
  logic signed [31:0] p2;
  logic [31:0] got_q [$];
  logic        rand_or = 1'b0;
  int          sent = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 32'hDEAD_BEEF;
  endfunction

  // DSP output: running sum of the pair presented L cycles earlier.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    mac_o = s_h.exists(cyc - L) ? s_h[cyc - L] : 32'd0;
  end

  // Random consumer backpressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Compare process: DSP model, output checks and model update each cycle.
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_rdy;
    logic exp_ol;
    logic fire;
    res_t r;
    // DSP: oload seen now applies to the product presented LD cycles ago
    a_h[cyc] = mac_a;
    b_h[cyc] = mac_b;
    if (a_h.exists(cyc - LD)) begin
      prod = $signed(a_h[cyc - LD]) * $signed(b_h[cyc - LD]);
      dsp_acc = mac_oload ? prod : dsp_acc + prod;
      s_h[cyc - LD] = dsp_acc;
    end

    if (rst) begin
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_mac_ce", {31'd0, mac_ce}, 32'd0);
      chk("rst_mac_a", {16'd0, mac_a}, 32'd0);
      chk("rst_mac_b", {16'd0, mac_b}, 32'd0);
      chk("rst_mac_oload", {31'd0, mac_oload}, 32'd0);
      exp_q.delete();
      if_h.delete();
      pending = 0;
      first_m = 1'b1;
      run_m = 1'b0;
      exp_a = 16'd0;
      exp_b = 16'd0;
    end else begin
      exp_rdy   = run_m && (!in_last || pending < 2);
      exp_valid = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
      exp_ol    = if_h.exists(cyc - LD) ? if_h[cyc - LD] : 1'b0;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("mac_ce", {31'd0, mac_ce}, {31'd0, run_m});
      chk("mac_a", {16'd0, mac_a}, {16'd0, exp_a});
      chk("mac_b", {16'd0, mac_b}, {16'd0, exp_b});
      chk("mac_oload", {31'd0, mac_oload}, {31'd0, exp_ol});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid) chk("out_data", out_data, exp_q[0].val);

      if (out_valid && out_ready) got_q.push_back(out_data);

      // model update for the coming edge
      fire = in_valid && in_ready;
      if_h[cyc + 1] = fire && first_m;
      if (fire) begin
        p2 = $signed(in_a) * $signed(in_b);
        sum_m = first_m ? p2 : sum_m + p2;
        if (in_last) begin
          r.rdy = cyc + L + 2;
          r.val = sum_m;
          exp_q.push_back(r);
          pending++;
        end
        first_m = in_last;
        exp_a = in_a;
        exp_b = in_b;
      end else begin
        exp_a = 16'd0;
        exp_b = 16'd0;
      end
      if (exp_valid && out_ready) begin
        void'(exp_q.pop_front());
        pending--;
      end
      run_m = 1'b1;
    end
  end

  // Present one pair and hold it until accepted (bounded).
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int w;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: pair %h,%h not accepted", a, b);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_a = 16'd0;
    in_b = 16'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || pending != 0) && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still expected", exp_q.size());
    end
    idle(2);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    // basic three-element vector: 12 + 30 - 14
    got_q.delete();
    send(16'd3, 16'd4, 1'b0);
    send(16'd5, 16'd6, 1'b0);
    send(-16'sd2, 16'd7, 1'b1);
    drain();
    chk("t1_count", got_q.size(), 32'd1);
    chk("t1_value", got_at(0), 32'h0000_001C);

    // most negative operands, single element
    got_q.delete();
    send(16'h8000, 16'h8000, 1'b1);
    drain();
    chk("t2_value", got_at(0), 32'h4000_0000);

    // largest positive products summed three times
    got_q.delete();
    send(16'h7FFF, 16'h7FFF, 1'b0);
    send(16'h7FFF, 16'h7FFF, 1'b0);
    send(16'h7FFF, 16'h7FFF, 1'b1);
    drain();
    chk("t3_value", got_at(0), 32'hBFFD_0003);

    // vector spanning bubbles
    got_q.delete();
    send(16'd1, 16'd1, 1'b0);
    idle(4);
    send(16'd2, 16'd2, 1'b0);
    idle(2);
    send(16'd3, 16'd3, 1'b1);
    drain();
    chk("t4_value", got_at(0), 32'd14);

    // backpressure: only two results may be owed
    got_q.delete();
    out_ready = 1'b0;
    sent = 0;
    fork
      begin
        for (int n = 1; n <= 4; n++) begin
          send(16'(n), 16'd1, 1'b1);
          sent++;
        end
      end
    join_none
    idle(20);
    chk("t5_stalled", sent, 32'd2);
    out_ready = 1'b1;
    wait fork;
    drain();
    chk("t5_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t5_order", got_at(i), 32'(i + 1));

    // back-to-back vectors
    got_q.delete();
    send(16'd2, 16'd3, 1'b1);
    send(16'd4, 16'd5, 1'b0);
    send(16'd1, 16'd1, 1'b1);
    drain();
    chk("t6_first", got_at(0), 32'd6);
    chk("t6_second", got_at(1), 32'd21);

    // reset in the middle of a vector
    got_q.delete();
    send(16'd9, 16'd9, 1'b0);
    send(16'd9, 16'd9, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(16'd1, 16'd2, 1'b1);
    drain();
    chk("t7_count", got_q.size(), 32'd1);
    chk("t7_value", got_at(0), 32'd2);

    // randomized stream with random backpressure
    rand_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
    end
    send(16'($urandom), 16'($urandom), 1'b1);
    rand_or = 1'b0;
    idle(1);
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
